// File: rtl/seq_subtractor.sv
// seq_subtractor: nibble-serial WIDTH-bit subtractor, D = A - B, one DIGIT-bit digit per clock.
// Subtraction is done as A + ~B with carry-in 1, rippling the carry LSB-first across STEPS edges.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   operands A/B present        in_ready   block can accept operands (IDLE)
//   A, B       minuend, subtrahend
//   out_valid  result valid and held       out_ready  consumer accepts result
//   D          A - B modulo 2^WIDTH
//   borrow     A < B unsigned (inverted final carry)
//   overflow   signed overflow of A - B
//   zero       D == 0
module seq_subtractor #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] D,
    output logic             borrow,
    output logic             overflow,
    output logic             zero
);

    localparam int unsigned Steps   = WIDTH / DIGIT;
    localparam int unsigned IdxW    = (Steps > 1) ? $clog2(Steps) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(Steps - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_q, b_q, d_q;
    logic              carry_q;
    logic [IdxW-1:0]   idx_q;
    logic              borrow_q, overflow_q, zero_q;

    logic [DIGIT-1:0]  a_dig, b_dig;
    logic [DIGIT:0]    sum;
    logic [WIDTH-1:0]  d_next;
    int unsigned       digit_lsb;

    // Current digit sum and the D value with that digit written in.
    always_comb begin
        digit_lsb = 32'(idx_q) * DIGIT;
        a_dig     = a_q[digit_lsb +: DIGIT];
        b_dig     = b_q[digit_lsb +: DIGIT];
        sum       = {1'b0, a_dig} + {1'b0, ~b_dig} + {{DIGIT{1'b0}}, carry_q};
        d_next    = d_q;
        d_next[digit_lsb +: DIGIT] = sum[DIGIT-1:0];
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (in_valid) state_d = StRun;
            StRun:   if (idx_q == LastIdx) state_d = StDone;
            StDone:  if (out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Handshake outputs.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            StIdle:  in_ready  = 1'b1;
            StDone:  out_valid = 1'b1;
            default: ;
        endcase
    end

    // Datapath: operand capture, digit-serial result build, flags on the last digit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q        <= '0;
            b_q        <= '0;
            d_q        <= '0;
            carry_q    <= 1'b1;
            idx_q      <= '0;
            borrow_q   <= 1'b0;
            overflow_q <= 1'b0;
            zero_q     <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        a_q     <= A;
                        b_q     <= B;
                        carry_q <= 1'b1;
                        idx_q   <= '0;
                    end
                end
                StRun: begin
                    d_q     <= d_next;
                    carry_q <= sum[DIGIT];
                    if (idx_q == LastIdx) begin
                        borrow_q   <= ~sum[DIGIT];
                        overflow_q <= (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                                      (d_next[WIDTH-1] != a_q[WIDTH-1]);
                        zero_q     <= (d_next == '0);
                    end else begin
                        idx_q <= idx_q + IdxW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign D        = d_q;
    assign borrow   = borrow_q;
    assign overflow = overflow_q;
    assign zero     = zero_q;

endmodule

// File: tb/tb_seq_subtractor.sv
module tb_seq_subtractor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] A, B;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] D;
    logic        borrow, overflow, zero;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    seq_subtractor #(.WIDTH(32), .DIGIT(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .A        (A),
        .B        (B),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .D        (D),
        .borrow   (borrow),
        .overflow (overflow),
        .zero     (zero)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] d;
        logic        brw;
        logic        ovf;
        logic        zr;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference: plain arithmetic on the operands.
    task automatic model(input logic [31:0] a, input logic [31:0] b, output logic [31:0] d,
                         output logic brw, output logic ovf, output logic zr);
        longint sd;
        d   = a - b;
        brw = (a < b);
        sd  = longint'($signed(a)) - longint'($signed(b));
        ovf = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
        zr  = (d == 32'd0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for in_ready and hand over one operand pair.
    task automatic accept(input logic [31:0] a, input logic [31:0] b, input string tag);
        int n = 0;
        while (!in_ready && n < 50) begin
            step();
            n++;
        end
        check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        A        = a;
        B        = b;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        A        = $urandom;
        B        = $urandom;
    endtask

    // Count edges until out_valid; must be exactly 8 after the accept edge.
    task automatic wait_result(input string tag);
        int lat = 0;
        while (!out_valid && lat < 20) begin
            check({tag, "_busy_in_ready"}, 64'(in_ready), 64'd0);
            step();
            lat++;
        end
        check({tag, "_latency"}, 64'(lat), 64'd8);
    endtask

    task automatic check_result(input string tag, input logic [31:0] ed, input logic eb,
                                input logic eo, input logic ez);
        check({tag, "_D"}, 64'(D), 64'(ed));
        check({tag, "_borrow"}, 64'(borrow), 64'(eb));
        check({tag, "_overflow"}, 64'(overflow), 64'(eo));
        check({tag, "_zero"}, 64'(zero), 64'(ez));
    endtask

    task automatic handshake(input string tag, input int delay);
        for (int i = 0; i < delay; i++) step();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({tag, "_ack_out_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_ack_in_ready"}, 64'(in_ready), 64'd1);
    endtask

    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] ed,
                         input logic eb, input logic eo, input logic ez, input string tag,
                         input int delay);
        accept(a, b, tag);
        wait_result(tag);
        check_result(tag, ed, eb, eo, ez);
        handshake(tag, delay);
    endtask

    initial begin
        logic [31:0] ra, rb, md;
        logic        mb, mo, mz;
        logic [31:0] held_d;
        logic [2:0]  held_f;

        vecs[0] = '{32'h0000_0005, 32'h0000_0003, 32'h0000_0002, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{32'h0001_0000, 32'h0000_0001, 32'h0000_FFFF, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0};
        vecs[8] = '{32'h0000_0000, 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1, 1'b0};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        A         = 32'd0;
        B         = 32'd0;
        step();
        step();
        rst_n = 1'b1;
        check("reset_in_ready", 64'(in_ready), 64'd1);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_D", 64'(D), 64'd0);
        check("reset_flags", 64'({borrow, overflow, zero}), 64'd0);

        foreach (vecs[i]) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].d, vecs[i].brw, vecs[i].ovf, vecs[i].zr,
                  $sformatf("vec%0d", i), 0);
        end

        // Backpressure: result must hold while in_valid and A/B wiggle.
        accept(32'h0000_1000, 32'h0000_0001, "bp");
        wait_result("bp");
        check_result("bp", 32'h0000_0FFF, 1'b0, 1'b0, 1'b0);
        held_d = D;
        held_f = {borrow, overflow, zero};
        for (int i = 0; i < 20; i++) begin
            in_valid = ~in_valid;
            A        = $urandom;
            B        = $urandom;
            step();
            check("bp_hold_D", 64'(D), 64'(held_d));
            check("bp_hold_flags", 64'({borrow, overflow, zero}), 64'(held_f));
            check("bp_hold_hs", 64'({out_valid, in_ready}), 64'b10);
        end
        // in_valid high on the ack edge must not be taken as a new operand.
        in_valid = 1'b1;
        handshake("bp", 0);
        in_valid = 1'b0;
        step();
        check("bp_no_turnaround", 64'(in_ready), 64'd1);

        // Reset at compute edge 4.
        accept(32'd100, 32'd1, "rst");
        step();
        step();
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("rst_mid_in_ready", 64'(in_ready), 64'd1);
        check("rst_mid_out_valid", 64'(out_valid), 64'd0);
        check("rst_mid_D", 64'(D), 64'd0);
        do_op(32'd10, 32'd20, 32'hFFFF_FFF6, 1'b1, 1'b0, 1'b0, "after_rst", 0);

        // Randomized operands against the reference model.
        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            rb = (i % 5 == 0) ? ra : $urandom;
            if (i % 7 == 3) rb = ra ^ 32'h8000_0000;
            model(ra, rb, md, mb, mo, mz);
            do_op(ra, rb, md, mb, mo, mz, $sformatf("rnd%0d", i), $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
